// File: rtl/mem_arbiter_if.sv
// Bundle of the two client ports and the memory-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              memWrite;
    logic              memRead;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataIn;
    logic [DATA_W-1:0] memDataOut;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  memDataOut,
        output ack0, rdata0, ack1, rdata1,
        output memWrite, memRead, memAddr, memDataIn
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output memDataOut,
        input  ack0, rdata0, ack1, rdata1,
        input  memWrite, memRead, memAddr, memDataIn
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
// Each transaction runs IDLE -> ACCESS -> RESP and completes with a one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          resetN,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic              winner;
    logic              cap_we;
    logic              cap_port;
    logic              last_grant;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // On a tie the port that was not granted last wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) winner = ~last_grant;
        else if (bus.req1)        winner = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.memWrite = 1'b0;
        bus.memRead  = 1'b0;
        bus.ack0     = 1'b0;
        bus.ack1     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) next_state = ACCESS;
            end
            ACCESS: begin
                bus.memWrite = cap_we;
                bus.memRead  = ~cap_we;
                next_state   = RESP;
            end
            RESP: begin
                bus.ack0   = ~cap_port;
                bus.ack1   = cap_port;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cap_we     <= 1'b0;
            cap_port   <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            last_grant <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        cap_port  <= winner;
                        cap_we    <= winner ? bus.we1    : bus.we0;
                        cap_addr  <= winner ? bus.addr1  : bus.addr0;
                        cap_wdata <= winner ? bus.wdata1 : bus.wdata0;
                    end
                end
                ACCESS: begin
                    if (!cap_we) begin
                        if (cap_port) rdata1_q <= bus.memDataOut;
                        else          rdata0_q <= bus.memDataOut;
                    end
                end
                RESP: last_grant <= cap_port;
                default: ;
            endcase
        end
    end

    assign bus.memAddr   = cap_addr;
    assign bus.memDataIn = cap_wdata;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-byte memory on the bus.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   passed = 0;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .resetN(resetN), .bus(bus));

    logic [7:0] mem_model [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.memWrite) mem_model[bus.memAddr] <= bus.memDataIn;
    assign bus.memDataOut = mem_model[bus.memAddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    // Runs one isolated transaction from IDLE and reports what was seen in ACCESS, RESP and the IDLE after.
    task automatic run_txn(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic acc_wr, output logic acc_rd, output logic [7:0] acc_addr,
                           output logic [7:0] acc_din, output logic resp_ack, output logic resp_other,
                           output logic resp_en, output logic [7:0] resp_rdata, output logic idle_ack);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        acc_wr   = bus.memWrite;
        acc_rd   = bus.memRead;
        acc_addr = bus.memAddr;
        acc_din  = bus.memDataIn;
        tick();
        resp_ack   = port ? bus.ack1 : bus.ack0;
        resp_other = port ? bus.ack0 : bus.ack1;
        resp_en    = bus.memWrite | bus.memRead;
        resp_rdata = port ? bus.rdata1 : bus.rdata0;
        tick();
        idle_ack = bus.ack0 | bus.ack1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetN = 1'b0;
        tick();
        tick();
        checks++; if (bus.ack0 !== 1'b0) $display("[TB] FAIL reset_ack0: got %b expected 0", bus.ack0); else passed++;
        checks++; if (bus.ack1 !== 1'b0) $display("[TB] FAIL reset_ack1: got %b expected 0", bus.ack1); else passed++;
        checks++; if (bus.rdata0 !== 8'h00) $display("[TB] FAIL reset_rdata0: got %h expected 00", bus.rdata0); else passed++;
        checks++; if (bus.rdata1 !== 8'h00) $display("[TB] FAIL reset_rdata1: got %h expected 00", bus.rdata1); else passed++;
        checks++; if (bus.memWrite !== 1'b0) $display("[TB] FAIL reset_memWrite: got %b expected 0", bus.memWrite); else passed++;
        checks++; if (bus.memRead !== 1'b0) $display("[TB] FAIL reset_memRead: got %b expected 0", bus.memRead); else passed++;
        checks++; if (bus.memAddr !== 8'h00) $display("[TB] FAIL reset_memAddr: got %h expected 00", bus.memAddr); else passed++;
        checks++; if (bus.memDataIn !== 8'h00) $display("[TB] FAIL reset_memDataIn: got %h expected 00", bus.memDataIn); else passed++;
        resetN = 1'b1;
    endtask

    task automatic test_write_read();
        logic wr, rd, ack, other, en, iack;
        logic [7:0] a, d, r;
        run_txn(1'b0, 1'b1, 8'h05, 8'hA5, wr, rd, a, d, ack, other, en, r, iack);
        checks++; if (wr !== 1'b1) $display("[TB] FAIL wr_memWrite: got %b expected 1", wr); else passed++;
        checks++; if (rd !== 1'b0) $display("[TB] FAIL wr_memRead: got %b expected 0", rd); else passed++;
        checks++; if (a !== 8'h05) $display("[TB] FAIL wr_memAddr: got %h expected 05", a); else passed++;
        checks++; if (d !== 8'hA5) $display("[TB] FAIL wr_memDataIn: got %h expected a5", d); else passed++;
        checks++; if (ack !== 1'b1 || other !== 1'b0) $display("[TB] FAIL wr_ack0: got %b/%b expected 1/0", ack, other); else passed++;
        checks++; if (en !== 1'b0) $display("[TB] FAIL wr_enable_in_resp: got %b expected 0", en); else passed++;
        checks++; if (r !== 8'h00) $display("[TB] FAIL wr_rdata0_unchanged: got %h expected 00", r); else passed++;
        checks++; if (iack !== 1'b0) $display("[TB] FAIL wr_ack_width: got %b expected 0", iack); else passed++;
        checks++; if (bus.memAddr !== 8'h05 || bus.memDataIn !== 8'hA5) $display("[TB] FAIL wr_hold: got %h/%h expected 05/a5", bus.memAddr, bus.memDataIn); else passed++;
        run_txn(1'b0, 1'b0, 8'h05, 8'h00, wr, rd, a, d, ack, other, en, r, iack);
        checks++; if (wr !== 1'b0 || rd !== 1'b1) $display("[TB] FAIL rd_enables: got %b/%b expected 0/1", wr, rd); else passed++;
        checks++; if (ack !== 1'b1) $display("[TB] FAIL rd_ack0: got %b expected 1", ack); else passed++;
        checks++; if (r !== 8'hA5) $display("[TB] FAIL rd_rdata0: got %h expected a5", r); else passed++;
        checks++; if (bus.rdata0 !== 8'hA5) $display("[TB] FAIL rd_rdata0_held: got %h expected a5", bus.rdata0); else passed++;
        checks++; if (bus.rdata1 !== 8'h00) $display("[TB] FAIL rd_rdata1_untouched: got %h expected 00", bus.rdata1); else passed++;
    endtask

    task automatic test_round_robin();
        logic exp0, exp1;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h05;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp0 = (k == 2) || (k == 8);
            exp1 = (k == 5) || (k == 11);
            checks++; if (bus.ack0 !== exp0) $display("[TB] FAIL rr_ack0 cycle %0d: got %b expected %b", k, bus.ack0, exp0); else passed++;
            checks++; if (bus.ack1 !== exp1) $display("[TB] FAIL rr_ack1 cycle %0d: got %b expected %b", k, bus.ack1, exp1); else passed++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_fill_read();
        logic wr, rd, ack, other, en, iack;
        logic [7:0] a, d, r;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 1'b1, 8'(i), 8'(i), wr, rd, a, d, ack, other, en, r, iack);
            checks++; if (ack !== 1'b1 || other !== 1'b0) $display("[TB] FAIL fill_ack1 %0d: got %b/%b expected 1/0", i, ack, other); else passed++;
        end
        checks++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) $display("[TB] FAIL fill_rdata_after_writes: got %h/%h expected 00/00", bus.rdata0, bus.rdata1); else passed++;
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, 1'b0, 8'(i), 8'h00, wr, rd, a, d, ack, other, en, r, iack);
            checks++; if (r !== 8'(i)) $display("[TB] FAIL fill_rdata0 %0d: got %h expected %h", i, r, 8'(i)); else passed++;
        end
        checks++; if (bus.rdata1 !== 8'h00) $display("[TB] FAIL fill_rdata1: got %h expected 00", bus.rdata1); else passed++;
    endtask

    task automatic test_addr_hold();
        logic wr, rd, ack, other, en, iack;
        logic [7:0] a, d, r;
        run_txn(1'b1, 1'b1, 8'h10, 8'h3C, wr, rd, a, d, ack, other, en, r, iack);
        run_txn(1'b1, 1'b1, 8'h20, 8'hC3, wr, rd, a, d, ack, other, en, r, iack);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        tick();
        bus.addr0 = 8'h20; bus.we0 = 1'b1; bus.wdata0 = 8'hEE;
        #1;
        checks++; if (bus.memAddr !== 8'h10) $display("[TB] FAIL hold_memAddr: got %h expected 10", bus.memAddr); else passed++;
        checks++; if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0) $display("[TB] FAIL hold_dir: got rd %b wr %b expected 1/0", bus.memRead, bus.memWrite); else passed++;
        bus.req0 = 1'b0;
        tick();
        checks++; if (bus.ack0 !== 1'b1) $display("[TB] FAIL hold_ack0: got %b expected 1", bus.ack0); else passed++;
        checks++; if (bus.rdata0 !== 8'h3C) $display("[TB] FAIL hold_rdata0: got %h expected 3c", bus.rdata0); else passed++;
        tick();
        clear_inputs();
        run_txn(1'b1, 1'b1, 8'hFF, 8'h5A, wr, rd, a, d, ack, other, en, r, iack);
        checks++; if (a !== 8'hFF) $display("[TB] FAIL ff_memAddr: got %h expected ff", a); else passed++;
        run_txn(1'b0, 1'b0, 8'hFF, 8'h00, wr, rd, a, d, ack, other, en, r, iack);
        checks++; if (r !== 8'h5A) $display("[TB] FAIL ff_rdata0: got %h expected 5a", r); else passed++;
    endtask

    task automatic test_reset_abort();
        logic wr, rd, ack, other, en, iack;
        logic [7:0] a, d, r;
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hFF;
        tick();
        bus.req0 = 1'b0;
        checks++; if (bus.memRead !== 1'b1) $display("[TB] FAIL abort_in_access: got %b expected 1", bus.memRead); else passed++;
        resetN = 1'b0;
        tick();
        checks++; if (bus.ack0 !== 1'b0) $display("[TB] FAIL abort_ack0: got %b expected 0", bus.ack0); else passed++;
        checks++; if (bus.rdata0 !== 8'h00) $display("[TB] FAIL abort_rdata0: got %h expected 00", bus.rdata0); else passed++;
        checks++; if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) $display("[TB] FAIL abort_enables: got %b/%b expected 0/0", bus.memRead, bus.memWrite); else passed++;
        resetN = 1'b1;
        tick();
        checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) $display("[TB] FAIL abort_late_ack: got %b/%b expected 0/0", bus.ack0, bus.ack1); else passed++;
        run_txn(1'b0, 1'b0, 8'hFF, 8'h00, wr, rd, a, d, ack, other, en, r, iack);
        checks++; if (rd !== 1'b1 || a !== 8'hFF) $display("[TB] FAIL abort_next_access: got rd %b addr %h expected 1/ff", rd, a); else passed++;
        checks++; if (ack !== 1'b1) $display("[TB] FAIL abort_next_ack0: got %b expected 1", ack); else passed++;
        checks++; if (r !== 8'h5A) $display("[TB] FAIL abort_next_rdata0: got %h expected 5a", r); else passed++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_fill_read();
        test_addr_hold();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
